parity_test_sequencer: RTL and testbench
========================================

PARITY_TEST_SEQUENCER -- requirements
Module: parity_test_sequencer

Interface
REQ-001 Parameter SEED, default 7'h01, first vector and LFSR seed; value 0 SHALL be replaced by 7'h01.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-005 abort  input  1  synchronous abandon of a run; return to IDLE.
REQ-006 limit  input  8  number of vectors per run; latched on accepted start.
REQ-007 F_davio  input  1  parity result from Davio parity unit under test.
REQ-008 F_conv  input  1  parity result from conventional parity unit under test.
REQ-009 D  output  7  test vector driven to both parity units.
REQ-010 busy  output  1  high in DRIVE and CHECK.
REQ-011 done  output  1  high while in DONE.
REQ-012 mismatch  output  1  one-cycle pulse per failing vector.
REQ-013 err_count  output  8  number of failing vectors in current/last run.
REQ-014 vec_count  output  8  number of vectors checked in current/last run.

Function
REQ-015 FSM states IDLE, DRIVE, CHECK, DONE; all outputs registered.
REQ-016 IDLE/DONE with start=1: latch limit, clear err_count and vec_count, load D with first vector, go DRIVE; done drops the same edge.
REQ-017 Accepted start with limit=0: go DONE directly, D unchanged, counts 0.
REQ-018 DRIVE: hold D one cycle for settling, unconditionally go CHECK.
REQ-019 CHECK: compare F_davio against F_conv; unequal -> err_count+1 and mismatch=1 for the following cycle only.
REQ-020 CHECK: vec_count+1; if new vec_count == latched limit go DONE, else advance D and go DRIVE.
REQ-021 Each vector SHALL take exactly 2 cycles; done asserts 2*limit cycles after the accepted start edge.
REQ-022 err_count SHALL not exceed vec_count (8 bits, limit <= 255, no overflow possible).
REQ-023 DONE: hold D, err_count, vec_count; stay until start or abort.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort=1 in any state: next state IDLE, mismatch=0, done=0, counts and D held; abort wins over simultaneous start.
REQ-026 Counter vector mode: D sequence SEED, SEED+1, ... modulo 128 (wraps 127 -> 0).

Reset
REQ-027 rst_n low: state IDLE, D=0, busy=0, done=0, mismatch=0, err_count=0, vec_count=0, immediately and regardless of clk.
REQ-028 Reset mid-run SHALL discard the run; no done pulse on release; first action after release requires a new start.

Configuration
REQ-029 Macro PARITY_SEQ_LFSR_EN defined: vector advance is 7-bit Fibonacci LFSR, next D = {D[5:0], D[6]^D[5]} (x^7+x^6+1, period 127, never 0).
REQ-030 Macro PARITY_SEQ_LFSR_EN undefined: vector advance is the incrementing counter of REQ-026; all other behaviour identical.

Verification
REQ-031 Counter mode, SEED=0, limit=10, both parity inputs = ^D -> D = 0..9, done 20 cycles after start, err_count=0, vec_count=10, mismatch never high.
REQ-032 Counter mode, limit=10, F_conv inverted only when D==3 -> one mismatch pulse, after CHECK of D=3, err_count=1, vec_count=10.
REQ-033 LFSR mode, SEED=1, limit=8 -> D = 01,02,04,08,10,20,41,03; done after 16 cycles.
REQ-034 limit=0 with start -> done one cycle later, busy never high, counts 0.
REQ-035 rst_n low during CHECK of vector 5 -> all outputs zero asynchronously, IDLE after release; abort during DRIVE of vector 4 -> IDLE next cycle, vec_count=3 held, done=0.
REQ-036 start pulsed while busy -> run unaffected; start in DONE -> new run, counts cleared.

Source files
------------

// File: rtl/parity_test_sequencer_if.sv
// rtl/parity_test_sequencer_if.sv - control, vector and result signals between the test host and the parity test sequencer
interface parity_test_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] limit;
    logic       F_davio;
    logic       F_conv;
    logic [6:0] D;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [7:0] err_count;
    logic [7:0] vec_count;

    modport master (
        output start, abort, limit, F_davio, F_conv,
        input  D, busy, done, mismatch, err_count, vec_count
    );

    modport slave (
        input  start, abort, limit, F_davio, F_conv,
        output D, busy, done, mismatch, err_count, vec_count
    );
endinterface

// File: rtl/parity_test_sequencer.sv
// rtl/parity_test_sequencer.sv - drives test vectors into two parity units and counts disagreements
// Optional PARITY_SEQ_LFSR_EN: vectors advance by a 7-bit Fibonacci LFSR instead of an incrementing counter.
module parity_test_sequencer #(
    parameter logic [6:0] SEED = 7'h01
) (
    input  logic                    clk,
    input  logic                    rst_n,
    parity_test_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef PARITY_SEQ_LFSR_EN
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [6:0] FIRST_VEC = (SEED == 7'd0) ? 7'h01 : SEED;
`else
    localparam logic [6:0] FIRST_VEC = SEED;
`endif

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_limit;
    logic [6:0] r_d;
    logic       r_busy;
    logic       r_done;
    logic       r_mismatch;
    logic [7:0] r_err_count;
    logic [7:0] r_vec_count;

    logic [7:0] w_limit_nxt;
    logic [6:0] w_d_nxt;
    logic       w_mismatch_nxt;
    logic [7:0] w_err_nxt;
    logic [7:0] w_vec_nxt;
    logic [6:0] w_adv;
    logic [7:0] w_vec_inc;
    logic       w_accept;

`ifdef PARITY_SEQ_LFSR_EN
    assign w_adv = {r_d[5:0], r_d[6] ^ r_d[5]};
`else
    assign w_adv = r_d + 7'd1;
`endif

    assign w_vec_inc = r_vec_count + 8'd1;
    assign w_accept  = bus.start && !bus.abort &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_limit     <= 8'd0;
            r_d         <= 7'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= 8'd0;
            r_vec_count <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_limit     <= w_limit_nxt;
            r_d         <= w_d_nxt;
            r_busy      <= (w_next_state == S_DRIVE) || (w_next_state == S_CHECK);
            r_done      <= (w_next_state == S_DONE);
            r_mismatch  <= w_mismatch_nxt;
            r_err_count <= w_err_nxt;
            r_vec_count <= w_vec_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_next_state = (bus.limit == 8'd0) ? S_DONE : S_DRIVE;
                    end
                end
                S_DRIVE: w_next_state = S_CHECK;
                S_CHECK: w_next_state = (w_vec_inc == r_limit) ? S_DONE : S_DRIVE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Abort leaves every held value alone and only suppresses the pulse.
    always_comb begin
        w_limit_nxt    = r_limit;
        w_d_nxt        = r_d;
        w_mismatch_nxt = 1'b0;
        w_err_nxt      = r_err_count;
        w_vec_nxt      = r_vec_count;
        if (w_accept) begin
            w_limit_nxt = bus.limit;
            w_err_nxt   = 8'd0;
            w_vec_nxt   = 8'd0;
            if (bus.limit != 8'd0) begin
                w_d_nxt = FIRST_VEC;
            end
        end else if (!bus.abort && (r_state == S_CHECK)) begin
            w_vec_nxt = w_vec_inc;
            if (bus.F_davio != bus.F_conv) begin
                w_err_nxt      = r_err_count + 8'd1;
                w_mismatch_nxt = 1'b1;
            end
            if (w_vec_inc != r_limit) begin
                w_d_nxt = w_adv;
            end
        end
    end

    assign bus.D         = r_d;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.mismatch  = r_mismatch;
    assign bus.err_count = r_err_count;
    assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_parity_test_sequencer.sv
// tb/tb_parity_test_sequencer.sv - directed self-checking bench for parity_test_sequencer
module tb_parity_test_sequencer;

    localparam logic [6:0] SEED = 7'h01;

    logic clk;
    logic rst_n;
    logic inj_en;
    logic [6:0] inj_val;
    int   n_tests;
    int   n_fail;
    logic [6:0] last_d;

    parity_test_sequencer_if bus();

    parity_test_sequencer #(.SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.F_davio = ^bus.D;
        bus.F_conv  = (^bus.D) ^ (inj_en && (bus.D == inj_val));
    end

    function automatic logic [6:0] adv(input logic [6:0] v);
`ifdef PARITY_SEQ_LFSR_EN
        return {v[5:0], v[6] ^ v[5]};
`else
        return v + 7'd1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] lim, input logic inj, input logic [6:0] ival, input logic noisy);
        logic [6:0] exp_d;
        int exp_err;
        logic exp_mis;
        inj_en  = inj;
        inj_val = ival;
        bus.limit = lim;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_d = SEED;
        exp_err = 0;
        for (int k = 0; k < lim; k++) begin
            check("drive_d", bus.D, exp_d);
            check("drive_busy", bus.busy, 1'b1);
            check("drive_done", bus.done, 1'b0);
            if (noisy && k == 1) bus.start = 1'b1;
            tick();
            check("check_mis_clear", bus.mismatch, 1'b0);
            tick();
            bus.start = 1'b0;
            exp_mis = inj && (exp_d == ival);
            if (exp_mis) exp_err++;
            check("mismatch", bus.mismatch, exp_mis);
            if (k != lim - 1) exp_d = adv(exp_d);
        end
        check("end_done", bus.done, 1'b1);
        check("end_busy", bus.busy, 1'b0);
        check("end_err", bus.err_count, exp_err);
        check("end_vec", bus.vec_count, lim);
        check("end_d", bus.D, exp_d);
        last_d = exp_d;
        tick();
        check("done_hold", bus.done, 1'b1);
        check("vec_hold", bus.vec_count, lim);
    endtask

    initial begin
        logic [6:0] v;
        n_tests = 0;
        n_fail = 0;
        inj_en = 1'b0;
        inj_val = 7'd0;
        last_d = 7'd0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.limit = 8'd0;
        #3;
        check("rst_d", bus.D, 7'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_mis", bus.mismatch, 1'b0);
        check("rst_err", bus.err_count, 8'd0);
        check("rst_vec", bus.vec_count, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", bus.busy, 1'b0);

        // clean run, then restart from DONE with one injected fault at D==3
        run(8'd10, 1'b0, 7'd0, 1'b0);
        run(8'd10, 1'b1, 7'd3, 1'b0);

        // limit 0: straight to DONE, D and counts untouched by the run
        bus.limit = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("lim0_done", bus.done, 1'b1);
        check("lim0_busy", bus.busy, 1'b0);
        check("lim0_vec", bus.vec_count, 8'd0);
        check("lim0_err", bus.err_count, 8'd0);
        check("lim0_d", bus.D, last_d);

        // start pulsed while busy must not disturb the run
        run(8'd4, 1'b0, 7'd0, 1'b1);

        // abort during DRIVE of vector 4
        bus.limit = 8'd10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        v = adv(adv(adv(SEED)));
        check("pre_abort_d", bus.D, v);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_vec", bus.vec_count, 8'd3);
        check("abort_d", bus.D, v);
        tick();
        check("abort_idle", bus.busy, 1'b0);

        // abort wins over a simultaneous start
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_busy", bus.busy, 1'b0);
        check("abort_start_vec", bus.vec_count, 8'd3);

        // reset asserted during CHECK of vector 5
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_vec", bus.vec_count, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_d", bus.D, 7'd0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_vec", bus.vec_count, 8'd0);
        check("arst_err", bus.err_count, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_done", bus.done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
